// File: rtl/demux_de_control_receptor.sv
// Receive-side symbol demux: sorts link bytes into control symbols and payload,
// and tracks ordered-set / packet framing for the Rx buffer logic.
//
// state | meaning
// IDLE  | between frames; only IDL/PAD are quiet, COM opens an ordered set
// OS    | inside an ordered set (COM, SKP, FTS symbols)
// PKT   | inside a packet opened by STP/SDP; payload bytes are counted

`ifndef COM
`define COM 8'hBC
`endif
`ifndef PAD
`define PAD 8'hF7
`endif
`ifndef SKP
`define SKP 8'h1C
`endif
`ifndef STP
`define STP 8'hFB
`endif
`ifndef SDP
`define SDP 8'h5C
`endif
`ifndef END
`define END 8'hFD
`endif
`ifndef EDB
`define EDB 8'hFE
`endif
`ifndef FTS
`define FTS 8'h3C
`endif
`ifndef IDL
`define IDL 8'h7C
`endif

module demux_de_control_receptor #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [7:0]       IN,
  input  logic             IN_VALID,
  output logic [3:0]       CONTROL,
  output logic [7:0]       Rx_Buffer,
  output logic             DATA_VALID,
  output logic             PKT_START,
  output logic             PKT_END,
  output logic             PKT_ABORT,
  output logic [LEN_W-1:0] PKT_LEN,
  output logic             ERROR
);

  localparam logic [3:0] C_COM = 4'd0, C_PAD = 4'd1, C_SKP = 4'd2, C_STP = 4'd3,
                         C_SDP = 4'd4, C_END = 4'd5, C_EDB = 4'd6, C_FTS = 4'd7,
                         C_IDL = 4'd8, C_DATA = 4'd9, C_UNK = 4'd15;
  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, OS, PKT} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [3:0]       control_q, control_d;
  logic [7:0]       rx_q, rx_d;
  logic             dv_q, dv_d;
  logic             start_q, start_d;
  logic             end_q, end_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;
  logic [3:0]       cls;

  function automatic logic [3:0] decode(input logic [7:0] b);
    case (b)
      `COM:    decode = C_COM;
      `PAD:    decode = C_PAD;
      `SKP:    decode = C_SKP;
      `STP:    decode = C_STP;
      `SDP:    decode = C_SDP;
      `END:    decode = C_END;
      `EDB:    decode = C_EDB;
      `FTS:    decode = C_FTS;
      `IDL:    decode = C_IDL;
      default: decode = C_UNK;
    endcase
  endfunction

  always_comb begin
    cls       = decode(IN);
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    control_d = control_q;
    rx_d      = rx_q;
    dv_d      = 1'b0;
    start_d   = 1'b0;
    end_d     = 1'b0;
    abort_d   = 1'b0;
    err_d     = 1'b0;
    if (IN_VALID) begin
      control_d = cls;
      case (state_q)
        IDLE: begin
          if (cls == C_COM) begin
            state_d = OS;
          end else if (cls == C_STP || cls == C_SDP) begin
            state_d = PKT;
            start_d = 1'b1;
            cnt_d   = '0;
          end else if (cls != C_IDL && cls != C_PAD) begin
            err_d = 1'b1;
          end
        end
        OS: begin
          if (cls == C_IDL || cls == C_PAD) begin
            state_d = IDLE;
          end else if (cls == C_STP || cls == C_SDP) begin
            state_d = PKT;
            start_d = 1'b1;
            cnt_d   = '0;
          end else if (cls != C_SKP && cls != C_FTS && cls != C_COM) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        PKT: begin
          if (cls == C_END) begin
            state_d = IDLE;
            end_d   = 1'b1;
            len_d   = cnt_q;
          end else if (cls == C_EDB) begin
            state_d = IDLE;
            abort_d = 1'b1;
            cnt_d   = '0;
          end else if (cls == C_STP || cls == C_SDP) begin
            // nested start: drop the open packet and begin a fresh one
            err_d   = 1'b1;
            abort_d = 1'b1;
            start_d = 1'b1;
            cnt_d   = '0;
          end else if (cnt_q >= MAX_CNT) begin
            control_d = C_DATA;
            err_d     = 1'b1;
            abort_d   = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
          end else begin
            control_d = C_DATA;
            rx_d      = IN;
            dv_d      = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      control_q <= C_IDL;
      rx_q      <= '0;
      dv_q      <= 1'b0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      control_q <= control_d;
      rx_q      <= rx_d;
      dv_q      <= dv_d;
      start_q   <= start_d;
      end_q     <= end_d;
      abort_q   <= abort_d;
      err_q     <= err_d;
    end
  end

  assign CONTROL    = control_q;
  assign Rx_Buffer  = rx_q;
  assign DATA_VALID = dv_q;
  assign PKT_START  = start_q;
  assign PKT_END    = end_q;
  assign PKT_ABORT  = abort_q;
  assign PKT_LEN    = len_q;
  assign ERROR      = err_q;

endmodule

// File: tb/tb_demux_de_control_receptor.sv
// Directed bench for demux_de_control_receptor: each driven byte queues its
// expected registered response; a monitor compares one cycle later.

module tb_demux_de_control_receptor;

  localparam int LEN_W = 7;
  localparam logic [7:0] S_COM = 8'hBC, S_PAD = 8'hF7, S_SKP = 8'h1C, S_STP = 8'hFB,
                         S_SDP = 8'h5C, S_END = 8'hFD, S_EDB = 8'hFE, S_FTS = 8'h3C,
                         S_IDL = 8'h7C;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       in_b = S_IDL;
  logic             in_valid = 1'b0;
  logic [3:0]       control;
  logic [7:0]       rx_buffer;
  logic             data_valid, pkt_start, pkt_end, pkt_abort, error;
  logic [LEN_W-1:0] pkt_len;

  typedef struct {
    string       tag;
    logic [23:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  demux_de_control_receptor #(.MAX_LEN(4), .LEN_W(LEN_W)) dut (
    .CLK(clk), .RESET(reset), .IN(in_b), .IN_VALID(in_valid),
    .CONTROL(control), .Rx_Buffer(rx_buffer), .DATA_VALID(data_valid),
    .PKT_START(pkt_start), .PKT_END(pkt_end), .PKT_ABORT(pkt_abort),
    .PKT_LEN(pkt_len), .ERROR(error)
  );

  always #5 clk = ~clk;

  // packed view: control, rx, dv, start, end, abort, len, err
  task automatic step(input string tag, input logic r, input logic v, input logic [7:0] b,
                      input logic [3:0] c, input logic [7:0] rx, input logic dv,
                      input logic st, input logic en, input logic ab,
                      input logic [6:0] len, input logic er);
    exp_t e;
    @(negedge clk);
    reset    = r;
    in_valid = v;
    in_b     = b;
    e.tag = tag;
    e.exp = {c, rx, dv, st, en, ab, len, er};
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    logic [23:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {control, rx_buffer, data_valid, pkt_start, pkt_end, pkt_abort, pkt_len, error};
        n_total++;
        if (act !== e.exp)
          $display("FAIL %s: got ctl=%0d rx=%h dv=%b st=%b en=%b ab=%b len=%0d err=%b, want ctl=%0d rx=%h dv=%b st=%b en=%b ab=%b len=%0d err=%b",
                   e.tag, act[23:20], act[19:12], act[11], act[10], act[9], act[8], act[7:1], act[0],
                   e.exp[23:20], e.exp[19:12], e.exp[11], e.exp[10], e.exp[9], e.exp[8], e.exp[7:1], e.exp[0]);
        else
          n_pass++;
      end
    end
  end

  initial begin
    //    tag          rst v  in      ctl  rx    dv st en ab len er
    step("rst0",       1, 0, S_IDL, 4'd8, 8'h00, 0, 0, 0, 0, 7'd0, 0);
    step("rst1",       1, 0, S_IDL, 4'd8, 8'h00, 0, 0, 0, 0, 7'd0, 0);
    for (int i = 0; i < 3; i++)
      step("idl",      0, 1, S_IDL, 4'd8, 8'h00, 0, 0, 0, 0, 7'd0, 0);
    step("pad",        0, 1, S_PAD, 4'd1, 8'h00, 0, 0, 0, 0, 7'd0, 0);
    step("p1_stp",     0, 1, S_STP, 4'd3, 8'h00, 0, 1, 0, 0, 7'd0, 0);
    step("p1_a5",      0, 1, 8'hA5, 4'd9, 8'hA5, 1, 0, 0, 0, 7'd0, 0);
    step("p1_3c",      0, 1, 8'h3C, 4'd9, 8'h3C, 1, 0, 0, 0, 7'd0, 0);
    step("p1_00",      0, 1, 8'h00, 4'd9, 8'h00, 1, 0, 0, 0, 7'd0, 0);
    step("p1_end",     0, 1, S_END, 4'd5, 8'h00, 0, 0, 1, 0, 7'd3, 0);
    step("os_com",     0, 1, S_COM, 4'd0, 8'h00, 0, 0, 0, 0, 7'd3, 0);
    for (int i = 0; i < 3; i++)
      step("os_skp",   0, 1, S_SKP, 4'd2, 8'h00, 0, 0, 0, 0, 7'd3, 0);
    step("os_fts",     0, 1, S_FTS, 4'd7, 8'h00, 0, 0, 0, 0, 7'd3, 0);
    step("os_idl",     0, 1, S_IDL, 4'd8, 8'h00, 0, 0, 0, 0, 7'd3, 0);
    step("p2_sdp",     0, 1, S_SDP, 4'd4, 8'h00, 0, 1, 0, 0, 7'd3, 0);
    step("p2_11",      0, 1, 8'h11, 4'd9, 8'h11, 1, 0, 0, 0, 7'd3, 0);
    step("p2_edb",     0, 1, S_EDB, 4'd6, 8'h11, 0, 0, 0, 1, 7'd3, 0);
    step("novalid",    0, 0, S_STP, 4'd6, 8'h11, 0, 0, 0, 0, 7'd3, 0);
    step("ov_stp",     0, 1, S_STP, 4'd3, 8'h11, 0, 1, 0, 0, 7'd3, 0);
    step("ov_01",      0, 1, 8'h01, 4'd9, 8'h01, 1, 0, 0, 0, 7'd3, 0);
    step("ov_02",      0, 1, 8'h02, 4'd9, 8'h02, 1, 0, 0, 0, 7'd3, 0);
    step("ov_03",      0, 1, 8'h03, 4'd9, 8'h03, 1, 0, 0, 0, 7'd3, 0);
    step("ov_04",      0, 1, 8'h04, 4'd9, 8'h04, 1, 0, 0, 0, 7'd3, 0);
    step("ov_05",      0, 1, 8'h05, 4'd9, 8'h04, 0, 0, 0, 1, 7'd3, 1);
    step("ov_end_err", 0, 1, S_END, 4'd5, 8'h04, 0, 0, 0, 0, 7'd3, 1);
    step("z_stp",      0, 1, S_STP, 4'd3, 8'h04, 0, 1, 0, 0, 7'd3, 0);
    step("z_end",      0, 1, S_END, 4'd5, 8'h04, 0, 0, 1, 0, 7'd0, 0);
    step("b2b_stp",    0, 1, S_STP, 4'd3, 8'h04, 0, 1, 0, 0, 7'd0, 0);
    step("nest_sdp",   0, 1, S_SDP, 4'd4, 8'h04, 0, 1, 0, 1, 7'd0, 1);
    step("nest_77",    0, 1, 8'h77, 4'd9, 8'h77, 1, 0, 0, 0, 7'd0, 0);
    step("nest_com",   0, 1, S_COM, 4'd9, 8'hBC, 1, 0, 0, 0, 7'd0, 0);
    step("nest_end",   0, 1, S_END, 4'd5, 8'hBC, 0, 0, 1, 0, 7'd2, 0);
    step("unk_idle",   0, 1, 8'h42, 4'd15, 8'hBC, 0, 0, 0, 0, 7'd2, 1);
    step("r_stp",      0, 1, S_STP, 4'd3, 8'hBC, 0, 1, 0, 0, 7'd2, 0);
    step("r_aa",       0, 1, 8'hAA, 4'd9, 8'hAA, 1, 0, 0, 0, 7'd2, 0);
    step("r_reset",    1, 1, S_END, 4'd8, 8'h00, 0, 0, 0, 0, 7'd0, 0);
    step("r_end_err",  0, 1, S_END, 4'd5, 8'h00, 0, 0, 0, 0, 7'd0, 1);
    step("os2_com",    0, 1, S_COM, 4'd0, 8'h00, 0, 0, 0, 0, 7'd0, 0);
    step("os2_edb",    0, 1, S_EDB, 4'd6, 8'h00, 0, 0, 0, 0, 7'd0, 1);
    step("os2_skp_id", 0, 1, S_SKP, 4'd2, 8'h00, 0, 0, 0, 0, 7'd0, 1);
    step("os3_com",    0, 1, S_COM, 4'd0, 8'h00, 0, 0, 0, 0, 7'd0, 0);
    step("os3_sdp",    0, 1, S_SDP, 4'd4, 8'h00, 0, 1, 0, 0, 7'd0, 0);
    step("os3_end",    0, 1, S_END, 4'd5, 8'h00, 0, 0, 1, 0, 7'd0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (sb.size() > 0) begin
      $display("FAIL drain: got %0d pending, want 0", sb.size());
      n_total++;
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/demux_de_control_receptor.md
Name: demux_de_control_receptor

Overview:
- Receive-side counterpart of the transmit control mux.
- Consumes the registered 8-bit symbol/data stream and classifies each byte as a control symbol or payload data.
- Tracks framing: ordered sets start with COM; packets start with STP/SDP and finish with END or EDB.
- Delivers payload bytes, framing pulses, packet length and error flags to the Rx buffer logic.

Parameters:
MAX_LEN, 64, maximum number of data bytes allowed in one packet
LEN_W, 7, width of the packet byte counter and PKT_LEN; must satisfy 2^LEN_W > MAX_LEN

Ports:
CLK  input  1  clock; all logic is on the rising edge
RESET  input  1  synchronous, active-high reset
IN  input  8  received byte from the link
IN_VALID  input  1  qualifies IN; when low, the byte is ignored
CONTROL  output  4  decoded class of the last accepted byte: 0 COM, 1 PAD, 2 SKP, 3 STP, 4 SDP, 5 END, 6 EDB, 7 FTS, 8 IDL, 9 DATA, 15 unknown
Rx_Buffer  output  8  payload byte; meaningful only when DATA_VALID is high
DATA_VALID  output  1  one-cycle pulse per accepted payload byte
PKT_START  output  1  one-cycle pulse when STP/SDP opens a packet
PKT_END  output  1  one-cycle pulse when END closes a packet normally
PKT_ABORT  output  1  one-cycle pulse when a packet is discarded (EDB, overflow, or nested start)
PKT_LEN  output  LEN_W  data byte count of the packet; valid in the PKT_END cycle and held until the next PKT_START
ERROR  output  1  one-cycle pulse on a protocol violation or unknown symbol

Behaviour:
- Symbol encodings are the shared define-file macros COM, PAD, SKP, STP, SDP, END, EDB, FTS, IDL. The decode compares IN against these macros.
- All outputs are registered, with 1-cycle latency from an accepted IN to its outputs.
- Reset, and RESET high at any time including mid-packet:
  - state goes to IDLE.
  - CONTROL=8, Rx_Buffer=0, PKT_LEN=0, byte counter=0.
  - All pulse outputs are 0.
  - No PKT_END or PKT_ABORT is emitted for the interrupted packet.
  - RESET has priority over every other event.
- IN_VALID=0:
  - State, counter, CONTROL, Rx_Buffer and PKT_LEN hold.
  - All pulses are 0 in the next cycle.
- States:
  - IDLE:
    - COM goes to OS.
    - STP/SDP goes to PKT: pulse PKT_START, clear the counter.
    - IDL/PAD stays in IDLE.
    - Any other byte stays in IDLE and pulses ERROR. CONTROL shows the decoded class, or 15 if the byte matches no macro.
  - OS:
    - SKP/FTS/COM stay in OS.
    - IDL/PAD go to IDLE.
    - STP/SDP go to PKT with PKT_START.
    - END/EDB/unknown byte: pulse ERROR, go to IDLE.
  - PKT:
    - END goes to IDLE: pulse PKT_END, PKT_LEN=counter, CONTROL=5.
    - EDB goes to IDLE: pulse PKT_ABORT, CONTROL=6.
    - STP/SDP: pulse ERROR and PKT_ABORT together with PKT_START in the same cycle, clear the counter, stay in PKT.
    - Any other byte is data: Rx_Buffer=IN, DATA_VALID=1, CONTROL=9, counter+1.
    - Inside PKT, bytes equal to non-framing macros (COM, SKP, etc.) are treated as data. The transmitter never sends END/EDB/STP/SDP values as payload.
- Overflow:
  - The data byte that brings the counter to MAX_LEN is accepted normally.
  - A further data byte is not delivered (DATA_VALID=0). Instead: pulse ERROR and PKT_ABORT, go to IDLE, clear the counter.
- Zero-length packet (STP followed directly by END): PKT_END with PKT_LEN=0.
- The counter saturates; it never wraps.
- Back-to-back packets (END then STP on consecutive cycles) are legal, with no idle cycle required.

Test Plan:
- RESET for 2 cycles, then IN=IDL for 3 cycles -> CONTROL=8, all pulses 0, PKT_LEN=0.
- IN=STP, 8'hA5, 8'h3C, 8'h00, END on consecutive cycles -> PKT_START 1 cycle after STP. DATA_VALID for 3 cycles with Rx_Buffer A5, 3C, 00 and CONTROL=9. Then PKT_END with PKT_LEN=3, CONTROL=5.
- IN=COM, SKP, SKP, SKP, IDL -> no ERROR, no DATA_VALID; CONTROL sequence 0, 2, 2, 2, 8.
- IN=SDP, 8'h11, EDB -> PKT_START, one DATA_VALID (11), then PKT_ABORT. No PKT_END; PKT_LEN unchanged.
- MAX_LEN=4: STP followed by 5 data bytes 8'h01..8'h05 -> DATA_VALID for 01..04 only. On byte 05: ERROR+PKT_ABORT, then IDLE, and a following END raises ERROR.
- STP, 8'hAA, RESET high one cycle, then END -> no PKT_END or PKT_ABORT. The END in IDLE raises ERROR.
